// File: rtl/sar_frontend_responder.sv
// sar_frontend_responder: host front end for a SAR controller; samples the input, requests a tracking direction, captures the final code.
// Latency: Valid two cycles after Start when the sample equals the last code, otherwise one cycle after the controller returns to idle.
// Backpressure: none; Start is ignored while Busy, and a controller that never finishes is abandoned after TMO cycles with Err.
module sar_frontend_responder #(
    parameter int DATA = 8,
    parameter int TMO  = 40
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Start,
    input  logic [DATA-1:0] AnalogIn,
    input  logic            ClockCmp,
    input  logic [1:0]      StateP,
    input  logic [DATA-1:0] SAROut,
    output logic            Inc,
    output logic            Dcr,
    output logic            Compare,
    output logic [DATA-1:0] Result,
    output logic            Valid,
    output logic            Busy,
    output logic            Err
);
    localparam int            CW      = $clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_CNT = CW'(TMO);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        CONVERT,
        CAPTURE,
        ERROR
    } state_t;

    state_t          state, state_nxt;
    logic [DATA-1:0] held, held_nxt;
    logic [DATA-1:0] last, last_nxt;
    logic [DATA-1:0] result_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic            saw_end, saw_end_nxt;
    logic            inc_nxt, dcr_nxt, valid_nxt, err_nxt;

    assign Busy = (state != IDLE);

    // Comparator decision, latched only on the controller's comparator clock.
    always_ff @(posedge ClockCmp or posedge Reset) begin
        if (Reset) begin
            Compare <= 1'b0;
        end else begin
            Compare <= (held >= SAROut);
        end
    end

    // Next-state and datapath decisions; every register holds unless a transition says otherwise.
    always_comb begin
        state_nxt   = state;
        held_nxt    = held;
        last_nxt    = last;
        result_nxt  = Result;
        cnt_nxt     = cnt;
        saw_end_nxt = saw_end;
        inc_nxt     = Inc;
        dcr_nxt     = Dcr;
        err_nxt     = Err;
        cnt_inc     = cnt + 1'b1;

        case (state)
            IDLE: begin
                // A request is only taken when the controller is parked, so it can see our direction cleanly.
                if (Start && (StateP == 2'b00)) begin
                    held_nxt  = AnalogIn;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                    inc_nxt   = (AnalogIn > last);
                    dcr_nxt   = (AnalogIn < last);
                    state_nxt = REQUEST;
                end
            end
            REQUEST: begin
                cnt_nxt = cnt_inc;
                if (held == last) begin
                    // Nothing to track: reuse the previous code without waking the controller.
                    result_nxt = last;
                    state_nxt  = CAPTURE;
                end else if (cnt_inc == TMO_CNT) begin
                    err_nxt   = 1'b1;
                    inc_nxt   = 1'b0;
                    dcr_nxt   = 1'b0;
                    state_nxt = ERROR;
                end else if (StateP != 2'b00) begin
                    inc_nxt     = 1'b0;
                    dcr_nxt     = 1'b0;
                    saw_end_nxt = 1'b0;
                    state_nxt   = CONVERT;
                end
            end
            CONVERT: begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == TMO_CNT) begin
                    err_nxt   = 1'b1;
                    inc_nxt   = 1'b0;
                    dcr_nxt   = 1'b0;
                    state_nxt = ERROR;
                end else begin
                    if (StateP == 2'b11) begin
                        saw_end_nxt = 1'b1;
                    end
                    // Idle after the final-bit state means the DAC code is the finished conversion.
                    if ((StateP == 2'b00) && saw_end) begin
                        result_nxt = SAROut;
                        last_nxt   = SAROut;
                        state_nxt  = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            ERROR: begin
                if (StateP == 2'b00) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Valid is high for exactly the single cycle spent in CAPTURE.
        valid_nxt = (state_nxt == CAPTURE);
    end

    // State and output registers; reset aborts any conversion immediately.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            held    <= '0;
            last    <= '0;
            Result  <= '0;
            cnt     <= '0;
            saw_end <= 1'b0;
            Inc     <= 1'b0;
            Dcr     <= 1'b0;
            Valid   <= 1'b0;
            Err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            held    <= held_nxt;
            last    <= last_nxt;
            Result  <= result_nxt;
            cnt     <= cnt_nxt;
            saw_end <= saw_end_nxt;
            Inc     <= inc_nxt;
            Dcr     <= dcr_nxt;
            Valid   <= valid_nxt;
            Err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sar_frontend_responder.sv
// Bench for sar_frontend_responder: a behavioural SAR controller drives the DUT, a scoreboard checks results.
// Latency: expectations are queued at Start and consumed when the DUT shows Busy rising, Valid, or Err rising.
// Backpressure: none; stimulus waits for Busy to drop before issuing the next request.
module tb_sar_frontend_responder;
    localparam int DATA = 8;
    localparam int TMO  = 40;

    logic            Clock    = 1'b0;
    logic            Reset    = 1'b1;
    logic            Start    = 1'b0;
    logic            ClockCmp = 1'b0;
    logic [DATA-1:0] AnalogIn = '0;
    logic [DATA-1:0] SAROut   = '0;
    logic [1:0]      StateP   = 2'b00;
    logic            Inc, Dcr, Compare, Valid, Busy, Err;
    logic [DATA-1:0] Result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit sar_en = 1'b1;

    typedef struct {
        logic [DATA-1:0] code;
        int              lat;
        int              start_cyc;
    } res_t;

    typedef struct {
        int              start_cyc;
        logic [DATA-1:0] keep;
    } err_t;

    logic [1:0] dir_q[$];
    res_t       res_q[$];
    err_t       err_q[$];

    // Reference model: the code the front end last captured (what it tracks against).
    logic [DATA-1:0] m_last = '0;

    sar_frontend_responder #(.DATA(DATA), .TMO(TMO)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .AnalogIn (AnalogIn),
        .ClockCmp (ClockCmp),
        .StateP   (StateP),
        .SAROut   (SAROut),
        .Inc      (Inc),
        .Dcr      (Dcr),
        .Compare  (Compare),
        .Result   (Result),
        .Valid    (Valid),
        .Busy     (Busy),
        .Err      (Err)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=event-mismatch required=scoreboard-event cycle=%0d", name, cyc);
    endtask

    // Successive-approximation controller: one bit per clock, final bit flagged with StateP=11.
    task automatic sar_convert();
        logic [DATA-1:0] code;
        logic [DATA-1:0] trial;
        code = '0;
        for (int b = DATA - 1; b >= 0; b--) begin
            if (b != DATA - 1) @(negedge Clock);
            if (Reset) begin
                StateP = 2'b00;
                return;
            end
            trial  = code | (DATA'(1) << b);
            SAROut = trial;
            StateP = (b == 0) ? 2'b11 : 2'b01;
            #1 ClockCmp = 1'b1;
            #1 ClockCmp = 1'b0;
            #1 if (Compare) code = trial;
        end
        @(negedge Clock);
        SAROut = code;
        StateP = 2'b00;
    endtask

    initial begin
        forever begin
            @(negedge Clock);
            if (sar_en && !Reset && (Inc || Dcr)) sar_convert();
        end
    end

    // Monitor: samples late in the low phase, pops expectations when the DUT shows an event.
    initial begin
        logic prev_busy, prev_err, prev_valid, prev_sp_nz;
        res_t r;
        err_t e;
        logic [1:0] d;
        prev_busy = 1'b0; prev_err = 1'b0; prev_valid = 1'b0; prev_sp_nz = 1'b0;
        forever begin
            @(negedge Clock);
            #4;
            if (Reset) begin
                prev_busy = 1'b0; prev_err = 1'b0; prev_valid = 1'b0; prev_sp_nz = 1'b0;
            end else begin
                chk("inc_dcr_exclusive", 32'(Inc && Dcr), 32'd0);
                chk("valid_err_exclusive", 32'(Valid && Err), 32'd0);
                if (Busy && prev_sp_nz) chk("dir_cleared_after_statep", 32'({Inc, Dcr}), 32'd0);
                if (Busy && !prev_busy) begin
                    chk("err_cleared_on_start", 32'(Err), 32'd0);
                    if (dir_q.size() == 0) fail("unexpected_start");
                    else begin
                        d = dir_q.pop_front();
                        chk("direction_inc_dcr", 32'({Inc, Dcr}), 32'(d));
                    end
                end
                if (Valid) begin
                    chk("valid_single_cycle", 32'(prev_valid), 32'd0);
                    if (res_q.size() == 0) fail("unexpected_valid");
                    else begin
                        r = res_q.pop_front();
                        chk("result", 32'(Result), 32'(r.code));
                        if (r.lat >= 0) chk("valid_latency", 32'(cyc - r.start_cyc), 32'(r.lat));
                    end
                end
                if (Err && !prev_err) begin
                    if (err_q.size() == 0) fail("unexpected_err");
                    else begin
                        e = err_q.pop_front();
                        chk("err_timing", 32'(cyc - e.start_cyc), 32'(TMO + 1));
                        chk("dir_cleared_on_err", 32'({Inc, Dcr}), 32'd0);
                        chk("result_kept_on_err", 32'(Result), 32'(e.keep));
                    end
                end
                prev_busy  = Busy;
                prev_err   = Err;
                prev_valid = Valid;
                prev_sp_nz = (StateP != 2'b00);
            end
        end
    end

    // Issue one accepted conversion at a negedge with Busy low; expectations come from the model.
    task automatic convert(input logic [DATA-1:0] v);
        res_t r;
        dir_q.push_back({v > m_last, v < m_last});
        r.code      = v;
        r.lat       = (v == m_last) ? 2 : -1;
        r.start_cyc = cyc;
        res_q.push_back(r);
        m_last   = v;
        AnalogIn = v;
        Start    = 1'b1;
        @(negedge Clock);
        Start    = 1'b0;
        AnalogIn = DATA'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (Busy && n < budget) begin
            @(negedge Clock);
            n++;
        end
        if (Busy) fail("busy_never_dropped");
    endtask

    task automatic wait_statep_active(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(posedge Clock);
            if (StateP == 2'b01) break;
            n++;
        end
        if (StateP != 2'b01) fail("controller_never_started");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_inc"}, 32'(Inc), 32'd0);
        chk({tag, "_dcr"}, 32'(Dcr), 32'd0);
        chk({tag, "_compare"}, 32'(Compare), 32'd0);
        chk({tag, "_valid"}, 32'(Valid), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_err"}, 32'(Err), 32'd0);
        chk({tag, "_result"}, 32'(Result), 32'd0);
    endtask

    initial begin
        err_t e;
        int   n;
        logic [DATA-1:0] v;

        repeat (3) @(negedge Clock);
        check_all_zero("in_reset");
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        check_all_zero("after_reset");

        // Tracking up from zero, then down, then the equal fast path.
        convert(8'h5A); wait_idle(60);
        convert(8'h13); wait_idle(60);
        convert(8'h13); wait_idle(60);

        // Controller stuck idle: direction held for TMO cycles, then Err with Result untouched.
        sar_en      = 1'b0;
        e.start_cyc = cyc;
        e.keep      = m_last;
        err_q.push_back(e);
        dir_q.push_back({8'h80 > m_last, 8'h80 < m_last});
        AnalogIn = 8'h80;
        Start    = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        n = 0;
        for (int i = 0; i < TMO + 5; i++) begin
            if (Inc) n++;
            @(negedge Clock);
        end
        chk("inc_hold_cycles", 32'(n), 32'(TMO));
        chk("err_sticky", 32'(Err), 32'd1);
        wait_idle(20);
        chk("err_sticky_in_idle", 32'(Err), 32'd1);
        sar_en = 1'b1;
        repeat (2) @(negedge Clock);
        convert(8'h22); wait_idle(60);
        chk("err_cleared_after_start", 32'(Err), 32'd0);

        // A second Start during CONVERT must not disturb the held sample.
        convert(8'h3C);
        wait_statep_active(10);
        @(negedge Clock);
        AnalogIn = 8'hC3;
        Start    = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        wait_idle(60);

        // Reset in the middle of a conversion: immediate abort, no Valid, tracking restarts from zero.
        repeat (2) @(negedge Clock);
        convert(8'hA7);
        wait_statep_active(10);
        #2 Reset = 1'b1;
        res_q.delete();
        m_last = '0;
        #1 check_all_zero("mid_reset");
        @(posedge Clock);
        @(posedge Clock);
        #2 Reset = 1'b0;
        @(negedge Clock);
        convert(8'h01); wait_idle(60);

        // Boundary codes and randomized tracking with frequent repeats.
        convert(8'hFF); wait_idle(60);
        convert(8'hFF); wait_idle(60);
        convert(8'h00); wait_idle(60);
        convert(8'h00); wait_idle(60);
        for (int k = 0; k < 20; k++) begin
            v = ($urandom_range(0, 3) == 0) ? m_last : DATA'($urandom);
            convert(v);
            wait_idle(60);
            repeat ($urandom_range(0, 3)) @(negedge Clock);
        end

        repeat (3) @(negedge Clock);
        chk("results_drained", 32'(res_q.size()), 32'd0);
        chk("directions_drained", 32'(dir_q.size()), 32'd0);
        chk("errors_drained", 32'(err_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=still-running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sar_frontend_responder.md
SAR_FRONTEND_RESPONDER -- requirements
Module: sar_frontend_responder

Interface
REQ-001 The module SHALL have parameter DATA, default 8, meaning the conversion word width in bits.
REQ-002 The module SHALL have parameter TMO, default 40, meaning the maximum number of Clock cycles allowed from request to capture.
REQ-003 The module SHALL have port Clock, input, 1 bit: system clock; all state updates on its rising edge except REQ-014.
REQ-004 The module SHALL have port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The module SHALL have port Start, input, 1 bit: conversion request from the host.
REQ-006 The module SHALL have port AnalogIn, input, DATA bits: digitised input level to be sampled.
REQ-007 The module SHALL have port ClockCmp, input, 1 bit: comparator latch clock from the SAR controller.
REQ-008 The module SHALL have port StateP, input, 2 bits: SAR controller state (00 idle, 01/10 search, 11 final bit).
REQ-009 The module SHALL have port SAROut, input, DATA bits: SAR controller DAC code.
REQ-010 The module SHALL have ports Inc and Dcr, outputs, 1 bit each, registered: tracking-direction requests to the controller.
REQ-011 The module SHALL have port Compare, output, 1 bit, registered: comparator decision to the controller.
REQ-012 The module SHALL have ports Result (output, DATA bits), Valid, Busy and Err (outputs, 1 bit each): captured code, 1-cycle result strobe, conversion in progress, timeout flag.

Function
REQ-013 The module SHALL hold internal registers Held and Last (DATA bits) plus a timeout counter of ceil(log2(TMO+1)) bits.
REQ-014 The module SHALL update Compare on each rising edge of ClockCmp to (Held >= SAROut), unsigned, and hold it otherwise.
REQ-015 The FSM SHALL have states IDLE, REQUEST, CONVERT, CAPTURE and ERROR; Busy SHALL be 1 in every state except IDLE.
REQ-016 In IDLE, with Start=1 and StateP=00, the FSM SHALL latch Held<=AnalogIn, clear the counter and go to REQUEST; Start SHALL otherwise be ignored, including while Busy=1.
REQ-017 On entry to REQUEST the FSM SHALL drive Inc=1 if Held>Last and Dcr=1 if Held<Last; Inc and Dcr SHALL never both be 1.
REQ-018 In REQUEST with Held==Last, the FSM SHALL go to CAPTURE without asserting Inc or Dcr, giving Valid two cycles after the Start edge.
REQ-019 In REQUEST, on the first edge at which StateP!=00, the FSM SHALL clear Inc and Dcr, clear the SawEnd flag and go to CONVERT.
REQ-020 In CONVERT the FSM SHALL set SawEnd when StateP=11; when StateP=00 and SawEnd=1 it SHALL go to CAPTURE.
REQ-021 On entry to CAPTURE the module SHALL load Result<=SAROut and Last<=SAROut; in the equal case of REQ-018 it SHALL load Result<=Last.
REQ-022 In CAPTURE the module SHALL pulse Valid=1 for exactly one Clock cycle, then return to IDLE.
REQ-023 The counter SHALL increment each cycle in REQUEST or CONVERT; on reaching TMO the FSM SHALL go to ERROR, set Err=1 and clear Inc and Dcr.
REQ-024 In ERROR the FSM SHALL wait for StateP=00 and then go to IDLE; Result and Last SHALL be unchanged.
REQ-025 Err SHALL be sticky, clearing only when the next Start is accepted or on Reset.
REQ-026 Valid and Err SHALL never both be 1 in the same cycle.

Reset
REQ-027 While Reset=1 the module SHALL hold: FSM=IDLE, Inc=Dcr=Compare=Valid=Busy=Err=0, Result=Held=Last=0, counter=0, SawEnd=0.
REQ-028 Reset asserted mid-conversion SHALL abort immediately with no Valid pulse; the first conversion after reset SHALL compare against Last=0.

Verification
REQ-029 Reset pulse, then idle -> all outputs 0, Busy=0, Result=0x00.
REQ-030 After reset, AnalogIn=0x5A, Start pulse, correct SAR controller attached -> Inc=1 only until StateP leaves 00, Dcr stays 0, Busy=1, then Result=0x5A with one Valid pulse.
REQ-031 Last=0x5A, AnalogIn=0x13, Start -> Dcr asserted, Inc=0, Result=0x13, Valid; then AnalogIn=0x13, Start -> no Inc/Dcr, Valid exactly 2 cycles after the Start edge, Result=0x13.
REQ-032 StateP forced to 00 permanently, AnalogIn=0x80, Start -> Inc held for TMO=40 cycles, then Err=1, Inc=0, Valid never asserted, Result unchanged; the next accepted Start clears Err.
REQ-033 Start pulsed during CONVERT with a different AnalogIn -> ignored; Held and Result reflect the original sample only.
REQ-034 Reset asserted while StateP=01 in CONVERT -> all outputs 0 the same cycle, no Valid pulse; a subsequent Start of 0x01 produces Inc.
